// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// One SHIFT cycle per input bit; the last completed result is held on bcd.
module bin2bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // state | meaning
  // IDLE  | waiting for start; bcd/overflow hold the previous result
  // SHIFT | one correct-then-shift iteration per input bit (WIDTH cycles)
  // DONE  | publish bcd/overflow, pulse done, return to IDLE

  localparam int BW = 4 * DIGITS + 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [31:0]          MAX_VAL   = 32'(10 ** DIGITS - 1);
  localparam logic [4*DIGITS-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [CW-1:0]        CNT_LOAD  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BW-1:0]    bcd_work;
  logic [BW-1:0]    bcd_adj;
  logic [WIDTH-1:0] bin_work;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  logic             in_range;

  always_comb begin
    in_range = (32'(bin) <= MAX_VAL);
  end

  // Correction works on the pre-shift value, including the guard nibble.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bcd_work <= '0;
      bin_work <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_work <= bin;
            bcd_work <= '0;
            cnt      <= CNT_LOAD;
            ovf_pend <= !in_range;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= {bcd_adj[BW-2:0], bin_work[WIDTH-1]};
          bin_work <= bin_work << 1;
          // A bit falling out of the guard nibble can only mean saturation.
          ovf_pend <= ovf_pend | bcd_adj[BW-1];
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          bcd      <= ovf_pend ? ALL_NINES : bcd_work[4*DIGITS-1:0];
          overflow <= ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected results,
// directed scenarios, and a strided sweep over the in-range values.
module tb_bin2bcd_seq;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin   = '0;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic [16:0] exp_q[$];
  logic [15:0] prev_bcd = '0;
  logic        prev_rst = 1'b0;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [16:0] model(input int v);
    int t;
    logic [15:0] r;
    if (v > 9999) return {1'b1, 16'h9999};
    t = v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic check_out(input string tag);
    logic [16:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_bcd"}, 32'(bcd), 32'(e[15:0]));
      chk({tag, "_ovf"}, 32'(overflow), 32'(e[16]));
    end
  endtask

  task automatic run_conv(input int v, input string tag);
    int n;
    exp_q.push_back(model(v));
    @(negedge clock);
    bin   = 14'(v);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bin   = 14'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd15);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    if (done === 1'b1) check_out(tag);
    else if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clock);
    chk({tag, "_pulse_width"}, 32'(done), 32'd0);
  endtask

  // bcd may only move on the cycle done is asserted.
  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (rst_n && prev_rst && bcd !== prev_bcd) chk("bcd_stable", 32'(done), 32'd1);
    prev_bcd = bcd;
    prev_rst = rst_n;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;

    repeat (3) @(negedge clock);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    run_conv(20, "b20");
    run_conv(9999, "max");
    run_conv(0, "zero");
    run_conv(12345, "ovf");
    run_conv(7, "after_ovf");
    run_conv(16383, "top");
    run_conv(10000, "ovf_edge");
    run_conv(9998, "near_max");

    // start held high: back-to-back conversions, bin glitch at edge 3 ignored
    for (int i = 0; i < 3; i++) exp_q.push_back(model(42));
    @(negedge clock);
    d0    = done_cnt;
    bin   = 14'd42;
    start = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clock);
      bin = (k % 16 == 2) ? 14'd999 : 14'd42;
      if (k == 46) start = 1'b0;
      if (done === 1'b1) begin
        chk("held_phase", 32'(k % 16), 32'd15);
        check_out("held");
      end
    end
    @(negedge clock);
    chk("held_count", 32'(done_cnt - d0), 32'd3);
    chk("held_idle", 32'(busy), 32'd0);

    // reset in the middle of a conversion
    @(negedge clock);
    bin   = 14'd1234;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_bcd_held", 32'(bcd), 32'd0);
    run_conv(5678, "post_rst");

    for (int v = 0; v <= 9999; v += 7) run_conv(v, "sweep");
    run_conv(9999, "sweep_end");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
